// File: rtl/fire_pkg.sv
// Shared widths, FSM encoding and helpers for the fire dispatcher.
package fire_pkg;

  localparam int TAG_W_DEF    = 8;
  localparam int ADDR_W_DEF   = 10;
  localparam int FAN_W_DEF    = 6;
  localparam int WEIGHT_W_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_PTR_RD = 3'd1;
  localparam state_t ST_PTR_LD = 3'd2;
  localparam state_t ST_SYN_RD = 3'd3;
  localparam state_t ST_SYN_LD = 3'd4;
  localparam state_t ST_EMIT   = 3'd5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fire_dispatch_stats.sv
// Saturating 16-bit spike and update counters; no added latency, no backpressure.
module fire_dispatch_stats
  import fire_pkg::*;
(
  input  logic        clk,
  input  logic        asyn_reset,
  input  logic        spike_inc,
  input  logic        upd_inc,
  output logic [15:0] spike_cnt,
  output logic [15:0] upd_cnt
);

  logic [15:0] spike_cnt_q, spike_cnt_d;
  logic [15:0] upd_cnt_q, upd_cnt_d;

  always_comb begin
    spike_cnt_d = spike_cnt_q;
    upd_cnt_d   = upd_cnt_q;
    if (spike_inc) spike_cnt_d = sat_inc16(spike_cnt_q);
    if (upd_inc)   upd_cnt_d   = sat_inc16(upd_cnt_q);
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      spike_cnt_q <= '0;
      upd_cnt_q   <= '0;
    end else begin
      spike_cnt_q <= spike_cnt_d;
      upd_cnt_q   <= upd_cnt_d;
    end
  end

  assign spike_cnt = spike_cnt_q;
  assign upd_cnt   = upd_cnt_q;

endmodule

// File: rtl/fire_dispatch.sv
// Walks a fired neuron's fanout list, one update per target; first upd_valid 4 edges after the dequeue,
// 3-cycle spacing; upd_valid/payload hold until upd_ready. DISPATCH_STATS_EN adds spike_cnt/upd_cnt.
module fire_dispatch
  import fire_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FAN_W    = FAN_W_DEF,
  parameter int WEIGHT_W = WEIGHT_W_DEF
) (
  input  logic                      clk,
  input  logic                      asyn_reset,
  input  logic                      fifo_empty,
  input  logic [TAG_W-1:0]          fifo_tag,
  output logic                      fifo_deq,
  output logic [TAG_W-1:0]          ptr_addr,
  input  logic [ADDR_W+FAN_W-1:0]   ptr_rdata,
  output logic [ADDR_W-1:0]         syn_addr,
  input  logic [TAG_W+WEIGHT_W-1:0] syn_rdata,
  output logic                      upd_valid,
  output logic [TAG_W-1:0]          upd_target,
  output logic [WEIGHT_W-1:0]       upd_weight,
  input  logic                      upd_ready,
  output logic                      busy
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]               spike_cnt,
  output logic [15:0]               upd_cnt
`endif
);

  state_t                state_q, state_d;
  logic [TAG_W-1:0]      ptr_addr_q, ptr_addr_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [FAN_W-1:0]      cnt_q, cnt_d;
  logic [FAN_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     syn_addr_q, syn_addr_d;
  logic                  upd_valid_q, upd_valid_d;
  logic [TAG_W-1:0]      upd_target_q, upd_target_d;
  logic [WEIGHT_W-1:0]   upd_weight_q, upd_weight_d;

  logic [ADDR_W-1:0]     ptr_base;
  logic [FAN_W-1:0]      ptr_cnt;
  logic [FAN_W-1:0]      idx_nxt;
  logic                  upd_hs;

  assign ptr_base = ptr_rdata[ADDR_W+FAN_W-1:FAN_W];
  assign ptr_cnt  = ptr_rdata[FAN_W-1:0];
  // idx never exceeds cnt-1, so idx+1 always fits in FAN_W bits
  assign idx_nxt  = idx_q + 1'b1;
  assign upd_hs   = upd_valid_q && upd_ready;

  // Gated by reset so a non-empty FIFO cannot be popped while held in reset
  assign fifo_deq = (state_q == ST_IDLE) && !fifo_empty && asyn_reset;

  always_comb begin
    state_d      = state_q;
    ptr_addr_d   = ptr_addr_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    syn_addr_d   = syn_addr_q;
    upd_valid_d  = upd_valid_q;
    upd_target_d = upd_target_q;
    upd_weight_d = upd_weight_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          ptr_addr_d = fifo_tag;
          state_d    = ST_PTR_RD;
        end
      end
      ST_PTR_RD: state_d = ST_PTR_LD;
      ST_PTR_LD: begin
        base_d = ptr_base;
        cnt_d  = ptr_cnt;
        idx_d  = '0;
        if (ptr_cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          syn_addr_d = ptr_base;
          state_d    = ST_SYN_RD;
        end
      end
      ST_SYN_RD: state_d = ST_SYN_LD;
      ST_SYN_LD: begin
        upd_target_d = syn_rdata[TAG_W+WEIGHT_W-1:WEIGHT_W];
        upd_weight_d = syn_rdata[WEIGHT_W-1:0];
        upd_valid_d  = 1'b1;
        state_d      = ST_EMIT;
      end
      ST_EMIT: begin
        if (upd_hs) begin
          upd_valid_d = 1'b0;
          idx_d       = idx_nxt;
          if (idx_nxt == cnt_q) begin
            state_d = ST_IDLE;
          end else begin
            // Address wraps modulo the synapse memory size
            syn_addr_d = base_q + ADDR_W'(idx_nxt);
            state_d    = ST_SYN_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge asyn_reset) begin
    if (!asyn_reset) begin
      state_q      <= ST_IDLE;
      ptr_addr_q   <= '0;
      base_q       <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      syn_addr_q   <= '0;
      upd_valid_q  <= 1'b0;
      upd_target_q <= '0;
      upd_weight_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_addr_q   <= ptr_addr_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      syn_addr_q   <= syn_addr_d;
      upd_valid_q  <= upd_valid_d;
      upd_target_q <= upd_target_d;
      upd_weight_q <= upd_weight_d;
    end
  end

  assign ptr_addr   = ptr_addr_q;
  assign syn_addr   = syn_addr_q;
  assign upd_valid  = upd_valid_q;
  assign upd_target = upd_target_q;
  assign upd_weight = upd_weight_q;
  assign busy       = (state_q != ST_IDLE);

`ifdef DISPATCH_STATS_EN
  fire_dispatch_stats u_stats (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .spike_inc  (fifo_deq),
    .upd_inc    (upd_hs),
    .spike_cnt  (spike_cnt),
    .upd_cnt    (upd_cnt)
  );
`endif

endmodule

// File: tb/tb_fire_dispatch.sv
// Bench for fire_dispatch: FIFO and memory models, payload scoreboard, vector table plus corner sequences.
module tb_fire_dispatch;

  logic        clk = 1'b0;
  logic        asyn_reset;
  logic        fifo_empty;
  logic [7:0]  fifo_tag;
  logic        fifo_deq;
  logic [7:0]  ptr_addr;
  logic [15:0] ptr_rdata;
  logic [9:0]  syn_addr;
  logic [23:0] syn_rdata;
  logic        upd_valid;
  logic [7:0]  upd_target;
  logic [15:0] upd_weight;
  logic        upd_ready;
  logic        busy;
`ifdef DISPATCH_STATS_EN
  logic [15:0] spike_cnt;
  logic [15:0] upd_cnt;
`endif

  always #5 clk = ~clk;

  fire_dispatch dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .fifo_empty (fifo_empty),
    .fifo_tag   (fifo_tag),
    .fifo_deq   (fifo_deq),
    .ptr_addr   (ptr_addr),
    .ptr_rdata  (ptr_rdata),
    .syn_addr   (syn_addr),
    .syn_rdata  (syn_rdata),
    .upd_valid  (upd_valid),
    .upd_target (upd_target),
    .upd_weight (upd_weight),
    .upd_ready  (upd_ready),
    .busy       (busy)
`ifdef DISPATCH_STATS_EN
    ,
    .spike_cnt  (spike_cnt),
    .upd_cnt    (upd_cnt)
`endif
  );

  // Show-ahead fire FIFO and synchronous-read memories
  logic [7:0]  fmem [64];
  logic [6:0]  wr_p = '0;
  logic [6:0]  rd_p = '0;
  logic [15:0] ptr_mem [256];

  assign fifo_empty = (wr_p == rd_p);
  assign fifo_tag   = fmem[rd_p[5:0]];

  // Weight field is unique per address, so payload checks also pin down syn_addr
  function automatic logic [23:0] syn_val(input logic [9:0] a);
    logic [15:0] w;
    w = 16'(int'(a) * 7 + 3);
    return {a[7:0] ^ 8'hA5, w};
  endfunction

  always @(posedge clk) begin
    ptr_rdata <= ptr_mem[ptr_addr];
    syn_rdata <= syn_val(syn_addr);
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int viol = 0;
  int spacing_bad = 0;
  int last_deq_cyc = 0;
  int last_hs_cyc = -1;
  int first_lat = -1;
  bit waiting_first = 0;
  bit chk_spacing = 0;
  logic [23:0] exp_q [$];
  int deq_log [$];

  typedef struct {
    logic [7:0] tag;
    logic [9:0] base;
    logic [5:0] cnt;
    int         exp_upd;
    int         exp_lat;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string nm, input longint act, input longint exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic push_tag(input logic [7:0] t);
    fmem[wr_p[5:0]] = t;
    wr_p = wr_p + 7'd1;
  endtask

  task automatic pop_loop();
    forever begin
      @(posedge clk);
      if (fifo_deq) rd_p <= rd_p + 7'd1;
    end
  endtask

  // Inputs only change just after posedge, so negedge values are what the next edge samples
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (!asyn_reset) begin
        exp_q.delete();
        waiting_first = 0;
      end else begin
        if (fifo_deq && fifo_empty) viol++;
        if (fifo_deq) begin
          logic [15:0] p;
          p = ptr_mem[fifo_tag];
          for (int i = 0; i < int'(p[5:0]); i++)
            exp_q.push_back(syn_val(p[15:6] + 10'(i)));
          deq_log.push_back(cyc);
          last_deq_cyc  = cyc;
          first_lat     = -1;
          waiting_first = 1;
          last_hs_cyc   = -1;
        end
        if (upd_valid && waiting_first) begin
          first_lat     = cyc - last_deq_cyc;
          waiting_first = 0;
        end
        if (upd_valid && upd_ready) begin
          hs_cnt++;
          if (chk_spacing && last_hs_cyc >= 0 && (cyc - last_hs_cyc) != 3) spacing_bad++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL upd_unexpected: got target %0d weight %0d, required none", upd_target, upd_weight);
          end else begin
            check("upd_payload", {upd_target, upd_weight}, exp_q.pop_front());
          end
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || !fifo_empty) && n < 3000);
    if (n >= 3000) check("idle_timeout", n, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_neg(input bit need_ready, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(upd_valid && (upd_ready || !need_ready)) && n < 200);
    if (n >= 200) check(nm, n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required done", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] cap;
    int h0;
    int n0;
    for (int i = 0; i < 256; i++) ptr_mem[i] = '0;
    // Dequeue is taken at the edge closing its cycle; upd_valid rises four edges later,
    // which is five sampled cycles after the cycle showing fifo_deq.
    vecs[0] = '{tag: 8'd5,  base: 10'd100,  cnt: 6'd3,  exp_upd: 3,  exp_lat: 5};
    vecs[1] = '{tag: 8'd9,  base: 10'd200,  cnt: 6'd1,  exp_upd: 1,  exp_lat: 5};
    vecs[2] = '{tag: 8'd20, base: 10'd500,  cnt: 6'd63, exp_upd: 63, exp_lat: 5};
    vecs[3] = '{tag: 8'd33, base: 10'd1000, cnt: 6'd30, exp_upd: 30, exp_lat: 5};
    vecs[4] = '{tag: 8'd40, base: 10'd0,    cnt: 6'd2,  exp_upd: 2,  exp_lat: 5};

    asyn_reset = 1'b0;
    upd_ready  = 1'b1;
    fork
      pop_loop();
      monitor_loop();
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {upd_valid, busy, fifo_deq, ptr_addr, syn_addr, upd_target, upd_weight}, 0);
    asyn_reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", {fifo_deq, busy, upd_valid}, 0);
    end
    @(posedge clk);
    #1;

    chk_spacing = 1;
    for (int v = 0; v < 5; v++) begin
      ptr_mem[vecs[v].tag] = {vecs[v].base, vecs[v].cnt};
      h0 = hs_cnt;
      n0 = deq_log.size();
      push_tag(vecs[v].tag);
      wait_idle();
      check("vec_deq_once", deq_log.size() - n0, 1);
      check("vec_upd_count", hs_cnt - h0, vecs[v].exp_upd);
      check("vec_first_lat", first_lat, vecs[v].exp_lat);
    end
    check("upd_spacing", spacing_bad, 0);

    // Zero fanout: back in IDLE three cycles after the dequeue, next tag taken at once
    ptr_mem[7] = {10'd300, 6'd0};
    ptr_mem[8] = {10'd700, 6'd2};
    n0 = deq_log.size();
    h0 = hs_cnt;
    push_tag(8'd7);
    push_tag(8'd8);
    wait_idle();
    if (deq_log.size() >= n0 + 2) check("zero_cnt_redeq", deq_log[n0+1] - deq_log[n0], 3);
    else check("zero_cnt_deqs", deq_log.size() - n0, 2);
    check("zero_cnt_upds", hs_cnt - h0, 2);

    // Address wrap 1023 -> 0
    ptr_mem[12] = {10'd1023, 6'd2};
    push_tag(8'd12);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("wrap_addr0", syn_addr, 1023);
    repeat (3) @(negedge clk);
    check("wrap_addr1", syn_addr, 0);
    wait_idle();
    chk_spacing = 0;

    // Backpressure: payload held while upd_ready is low
    ptr_mem[50] = {10'd300, 6'd1};
    upd_ready = 1'b0;
    h0 = hs_cnt;
    push_tag(8'd50);
    wait_neg(1'b0, "stall_valid_timeout");
    cap = {upd_target, upd_weight};
    check("stall_payload", cap, syn_val(10'd300));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold", {upd_valid, upd_target, upd_weight}, {1'b1, cap});
    end
    @(posedge clk);
    #1;
    upd_ready = 1'b1;
    wait_idle();
    check("stall_one_upd", hs_cnt - h0, 1);
`ifdef DISPATCH_STATS_EN
    check("stats_spike", spike_cnt, deq_log.size());
    check("stats_upd", upd_cnt, hs_cnt);
`endif

    // Reset during the second of three updates
    ptr_mem[60] = {10'd400, 6'd3};
    ptr_mem[61] = {10'd10, 6'd1};
    n0 = deq_log.size();
    push_tag(8'd60);
    push_tag(8'd61);
    wait_neg(1'b1, "rst_first_timeout");
    @(posedge clk);
    #1;
    upd_ready = 1'b0;
    wait_neg(1'b0, "rst_second_timeout");
    @(posedge clk);
    #1;
    asyn_reset = 1'b0;
    #1;
    check("rst_mid_outs", {upd_valid, busy, fifo_deq, ptr_addr, syn_addr, upd_target, upd_weight}, 0);
    check("rst_fifo_kept", fifo_empty, 0);
`ifdef DISPATCH_STATS_EN
    check("rst_stats", {spike_cnt, upd_cnt}, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    asyn_reset = 1'b1;
    upd_ready  = 1'b1;
    wait_idle();
    check("rst_deq_count", deq_log.size() - n0, 2);

    check("sb_empty", exp_q.size(), 0);
    check("deq_while_empty", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fire_dispatch.md
FIRE_DISPATCH -- requirements
Module: fire_dispatch

Interface
REQ-001 SHALL have parameter TAG_W, default 8, neuron id width.
REQ-002 SHALL have parameter ADDR_W, default 10, synapse memory address width.
REQ-003 SHALL have parameter FAN_W, default 6, fanout count width.
REQ-004 SHALL have parameter WEIGHT_W, default 16, synaptic weight width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port asyn_reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port fifo_empty  input  1  fire FIFO empty flag.
REQ-008 SHALL have port fifo_tag  input  TAG_W  fired neuron id; show-ahead, valid whenever fifo_empty=0.
REQ-009 SHALL have port fifo_deq  output  1  one-cycle dequeue pulse to fire FIFO.
REQ-010 SHALL have port ptr_addr  output  TAG_W  pointer table read address.
REQ-011 SHALL have port ptr_rdata  input  ADDR_W+FAN_W  {base, count}; valid one cycle after ptr_addr is presented.
REQ-012 SHALL have port syn_addr  output  ADDR_W  synapse memory read address.
REQ-013 SHALL have port syn_rdata  input  TAG_W+WEIGHT_W  {target, weight}; valid one cycle after syn_addr is presented.
REQ-014 SHALL have ports upd_valid/upd_target/upd_weight  output  1/TAG_W/WEIGHT_W  synaptic update to accumulator.
REQ-015 SHALL have port upd_ready  input  1  accumulator accepts update.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, PTR_RD, PTR_LD, SYN_RD, SYN_LD, EMIT.
REQ-018 IDLE: fifo_empty=0 -> assert fifo_deq for exactly one cycle, latch fifo_tag, go PTR_RD; fifo_empty=1 -> stay, fifo_deq=0.
REQ-019 SHALL never assert fifo_deq while fifo_empty=1 or outside IDLE.
REQ-020 PTR_RD: drive ptr_addr=latched tag; go PTR_LD.
REQ-021 PTR_LD: latch base and count from ptr_rdata, clear index; count=0 -> IDLE (zero updates), else SYN_RD.
REQ-022 SYN_RD: drive syn_addr=(base+index) mod 2^ADDR_W (wraps, no carry out); go SYN_LD.
REQ-023 SYN_LD: register target and weight into upd_target/upd_weight, set upd_valid; go EMIT.
REQ-024 EMIT: hold upd_valid and payload stable until upd_valid&&upd_ready; on handshake index+1, clear upd_valid; index+1==count -> IDLE else SYN_RD.
REQ-025 Latency: fifo_deq to first upd_valid = 4 cycles; with upd_ready tied high, update-to-update spacing = 3 cycles.
REQ-026 count = 2^FAN_W-1 SHALL emit exactly that many updates; index SHALL not overflow.
REQ-027 upd_ready asserted while upd_valid=0 SHALL be ignored.

Reset
REQ-028 asyn_reset=0 SHALL immediately force IDLE, fifo_deq=0, upd_valid=0, busy=0, and ptr_addr/syn_addr/upd_target/upd_weight/index/base/count to 0.
REQ-029 Reset mid-dispatch SHALL abandon the current neuron's remaining updates without re-dequeue.

Configuration
REQ-030 With DISPATCH_STATS_EN defined, SHALL add outputs spike_cnt (16 bits, +1 per fifo_deq) and upd_cnt (16 bits, +1 per update handshake), both saturating at 16'hFFFF, reset to 0.
REQ-031 Without DISPATCH_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-032 Shared package fire_pkg SHALL hold default widths and the state encoding typedef.
REQ-033 Counters SHALL live in sub-module fire_dispatch_stats, instantiated only under DISPATCH_STATS_EN.

Verification
REQ-034 Reset then fifo_empty=1 for 10 cycles -> fifo_deq=0, busy=0, upd_valid=0 throughout.
REQ-035 Tag 5, ptr {base=100,count=3}, upd_ready=1 -> one fifo_deq, syn_addr 100,101,102, three updates, first upd_valid 4 cycles after deq, return to IDLE.
REQ-036 Tag 7 with count=0 -> one deq, no upd_valid, IDLE after 3 cycles, next tag dequeued immediately.
REQ-037 base=1023, count=2, ADDR_W=10 -> syn_addr 1023 then 0.
REQ-038 upd_ready low 5 cycles during EMIT -> upd_valid, upd_target, upd_weight stable; one update counted.
REQ-039 asyn_reset low during second of three updates -> immediate IDLE, upd_valid=0; with DISPATCH_STATS_EN spike_cnt=0, upd_cnt=0.
